writeback_regfile: RTL and testbench

Writeback stage and architectural register state of the VLIW FP processor. Captures the integer and FP results presented by the execute stage at the end of each cycle. Commits them to a 16×32 integer register file and a 16×FP_W FP register file, and latches the condition flags. Serves the combinational read ports used by decode to form da/db and FP_d1a/d1b/d2a/d2b.

---
 rtl/writeback_regfile.sv | 114 +++++++++++
 tb/tb_writeback_regfile.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Writeback stage: 16x32 integer and 16xFP_W FP register files plus latched condition flags.
// Optional macro WB_BYPASS_EN forwards same-cycle writes straight onto the read ports.
module writeback_regfile #(
    parameter int FP_W = 64
) (
    input  logic            clock,
    input  logic            nReset,
    input  logic [31:0]     ed1,
    input  logic [31:0]     ed2,
    input  logic [3:0]      ewn1,
    input  logic [3:0]      ewn2,
    input  logic            ewreg1,
    input  logic            ewreg2,
    input  logic            INT_Neg,
    input  logic            INT_Zero,
    input  logic [FP_W-1:0] eFP_ed1,
    input  logic [FP_W-1:0] eFP_ed2,
    input  logic [3:0]      eFP_Wn_CH1,
    input  logic [3:0]      eFP_Wn_CH2,
    input  logic            eFP_WReg_CH1,
    input  logic            eFP_WReg_CH2,
    input  logic            FP_Neg_CH1,
    input  logic            FP_Neg_CH2,
    input  logic            FP_Zero_CH1,
    input  logic            FP_Zero_CH2,
    input  logic [3:0]      ra,
    input  logic [3:0]      rb,
    output logic [31:0]     qa,
    output logic [31:0]     qb,
    input  logic [3:0]      fr1a,
    input  logic [3:0]      fr1b,
    input  logic [3:0]      fr2a,
    input  logic [3:0]      fr2b,
    output logic [FP_W-1:0] fq1a,
    output logic [FP_W-1:0] fq1b,
    output logic [FP_W-1:0] fq2a,
    output logic [FP_W-1:0] fq2b,
    output logic [1:0]      IntFlags,
    output logic [1:0]      FPFlags_CH1,
    output logic [1:0]      FPFlags_CH2
);

    logic [31:0]     int_q [16];
    logic [31:0]     int_d [16];
    logic [FP_W-1:0] fp_q  [16];
    logic [FP_W-1:0] fp_d  [16];
    logic [1:0]      int_flags_q, int_flags_d;
    logic [1:0]      fp_flags1_q, fp_flags1_d;
    logic [1:0]      fp_flags2_q, fp_flags2_d;

    // Port/channel 2 is applied last so it wins a same-destination collision.
    always_comb begin
        int_d       = int_q;
        fp_d        = fp_q;
        int_flags_d = int_flags_q;
        fp_flags1_d = fp_flags1_q;
        fp_flags2_d = fp_flags2_q;
        if (ewreg1) begin
            int_d[ewn1] = ed1;
            int_flags_d = {INT_Neg, INT_Zero};
        end
        if (ewreg2) begin
            int_d[ewn2] = ed2;
        end
        if (eFP_WReg_CH1) begin
            fp_d[eFP_Wn_CH1] = eFP_ed1;
            fp_flags1_d      = {FP_Neg_CH1, FP_Zero_CH1};
        end
        if (eFP_WReg_CH2) begin
            fp_d[eFP_Wn_CH2] = eFP_ed2;
            fp_flags2_d      = {FP_Neg_CH2, FP_Zero_CH2};
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 16; i++) begin
                int_q[i] <= '0;
                fp_q[i]  <= '0;
            end
            int_flags_q <= '0;
            fp_flags1_q <= '0;
            fp_flags2_q <= '0;
        end else begin
            int_q       <= int_d;
            fp_q        <= fp_d;
            int_flags_q <= int_flags_d;
            fp_flags1_q <= fp_flags1_d;
            fp_flags2_q <= fp_flags2_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Next-state view already carries the priority-resolved incoming writes; gate it so reads stay 0 in reset.
    assign qa   = nReset ? int_d[ra]  : '0;
    assign qb   = nReset ? int_d[rb]  : '0;
    assign fq1a = nReset ? fp_d[fr1a] : '0;
    assign fq1b = nReset ? fp_d[fr1b] : '0;
    assign fq2a = nReset ? fp_d[fr2a] : '0;
    assign fq2b = nReset ? fp_d[fr2b] : '0;
`else
    assign qa   = int_q[ra];
    assign qb   = int_q[rb];
    assign fq1a = fp_q[fr1a];
    assign fq1b = fp_q[fr1b];
    assign fq2a = fp_q[fr2a];
    assign fq2b = fp_q[fr2b];
`endif

    assign IntFlags    = int_flags_q;
    assign FPFlags_CH1 = fp_flags1_q;
    assign FPFlags_CH2 = fp_flags2_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios plus randomized traffic against an array model.
module tb_writeback_regfile;

    localparam int FP_W = 64;

    logic            clock = 1'b0;
    logic            nReset;
    logic [31:0]     ed1, ed2;
    logic [3:0]      ewn1, ewn2;
    logic            ewreg1, ewreg2;
    logic            INT_Neg, INT_Zero;
    logic [FP_W-1:0] eFP_ed1, eFP_ed2;
    logic [3:0]      eFP_Wn_CH1, eFP_Wn_CH2;
    logic            eFP_WReg_CH1, eFP_WReg_CH2;
    logic            FP_Neg_CH1, FP_Neg_CH2, FP_Zero_CH1, FP_Zero_CH2;
    logic [3:0]      ra, rb, fr1a, fr1b, fr2a, fr2b;
    logic [31:0]     qa, qb;
    logic [FP_W-1:0] fq1a, fq1b, fq2a, fq2b;
    logic [1:0]      IntFlags, FPFlags_CH1, FPFlags_CH2;

    writeback_regfile #(.FP_W(FP_W)) dut (
        .clock(clock), .nReset(nReset),
        .ed1(ed1), .ed2(ed2), .ewn1(ewn1), .ewn2(ewn2), .ewreg1(ewreg1), .ewreg2(ewreg2),
        .INT_Neg(INT_Neg), .INT_Zero(INT_Zero),
        .eFP_ed1(eFP_ed1), .eFP_ed2(eFP_ed2), .eFP_Wn_CH1(eFP_Wn_CH1), .eFP_Wn_CH2(eFP_Wn_CH2),
        .eFP_WReg_CH1(eFP_WReg_CH1), .eFP_WReg_CH2(eFP_WReg_CH2),
        .FP_Neg_CH1(FP_Neg_CH1), .FP_Neg_CH2(FP_Neg_CH2),
        .FP_Zero_CH1(FP_Zero_CH1), .FP_Zero_CH2(FP_Zero_CH2),
        .ra(ra), .rb(rb), .qa(qa), .qb(qb),
        .fr1a(fr1a), .fr1b(fr1b), .fr2a(fr2a), .fr2b(fr2b),
        .fq1a(fq1a), .fq1b(fq1b), .fq2a(fq2a), .fq2b(fq2b),
        .IntFlags(IntFlags), .FPFlags_CH1(FPFlags_CH1), .FPFlags_CH2(FPFlags_CH2)
    );

    always #5 clock = ~clock;

    // Architectural model
    logic [31:0]     m_int [16];
    logic [FP_W-1:0] m_fp  [16];
    logic [1:0]      m_iflags, m_fflags1, m_fflags2;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_int[i] = '0;
            m_fp[i]  = '0;
        end
        m_iflags  = '0;
        m_fflags1 = '0;
        m_fflags2 = '0;
    endtask

    function automatic logic [31:0] exp_int(input logic [3:0] a);
`ifdef WB_BYPASS_EN
        if (nReset && ewreg2 && ewn2 == a) return ed2;
        if (nReset && ewreg1 && ewn1 == a) return ed1;
`endif
        return m_int[a];
    endfunction

    function automatic logic [FP_W-1:0] exp_fp(input logic [3:0] a);
`ifdef WB_BYPASS_EN
        if (nReset && eFP_WReg_CH2 && eFP_Wn_CH2 == a) return eFP_ed2;
        if (nReset && eFP_WReg_CH1 && eFP_Wn_CH1 == a) return eFP_ed1;
`endif
        return m_fp[a];
    endfunction

    task automatic check_all(input string pfx);
        check({pfx, ".qa"},   64'(qa),   64'(exp_int(ra)));
        check({pfx, ".qb"},   64'(qb),   64'(exp_int(rb)));
        check({pfx, ".fq1a"}, 64'(fq1a), 64'(exp_fp(fr1a)));
        check({pfx, ".fq1b"}, 64'(fq1b), 64'(exp_fp(fr1b)));
        check({pfx, ".fq2a"}, 64'(fq2a), 64'(exp_fp(fr2a)));
        check({pfx, ".fq2b"}, 64'(fq2b), 64'(exp_fp(fr2b)));
        check({pfx, ".iflg"}, 64'(IntFlags),    64'(m_iflags));
        check({pfx, ".fflg1"}, 64'(FPFlags_CH1), 64'(m_fflags1));
        check({pfx, ".fflg2"}, 64'(FPFlags_CH2), 64'(m_fflags2));
    endtask

    // Advance one clock; the model commits the writes presented this cycle unless reset is held.
    task automatic step();
        @(posedge clock);
        if (nReset) begin
            if (ewreg1) begin
                m_int[ewn1] = ed1;
                m_iflags    = {INT_Neg, INT_Zero};
            end
            if (ewreg2) m_int[ewn2] = ed2;
            if (eFP_WReg_CH1) begin
                m_fp[eFP_Wn_CH1] = eFP_ed1;
                m_fflags1        = {FP_Neg_CH1, FP_Zero_CH1};
            end
            if (eFP_WReg_CH2) begin
                m_fp[eFP_Wn_CH2] = eFP_ed2;
                m_fflags2        = {FP_Neg_CH2, FP_Zero_CH2};
            end
        end else begin
            model_clear();
        end
        #1;
    endtask

    task automatic idle();
        ewreg1 = 0; ewreg2 = 0; eFP_WReg_CH1 = 0; eFP_WReg_CH2 = 0;
        ed1 = '0; ed2 = '0; ewn1 = '0; ewn2 = '0;
        eFP_ed1 = '0; eFP_ed2 = '0; eFP_Wn_CH1 = '0; eFP_Wn_CH2 = '0;
        INT_Neg = 0; INT_Zero = 0; FP_Neg_CH1 = 0; FP_Neg_CH2 = 0; FP_Zero_CH1 = 0; FP_Zero_CH2 = 0;
        ra = '0; rb = '0; fr1a = '0; fr1b = '0; fr2a = '0; fr2b = '0;
    endtask

    task automatic randomize_inputs();
        ewreg1 = 1'($urandom); ewreg2 = 1'($urandom);
        eFP_WReg_CH1 = 1'($urandom); eFP_WReg_CH2 = 1'($urandom);
        ed1 = $urandom; ed2 = $urandom;
        ewn1 = 4'($urandom); ewn2 = ($urandom_range(0, 3) == 0) ? ewn1 : 4'($urandom);
        eFP_ed1 = {$urandom, $urandom}; eFP_ed2 = {$urandom, $urandom};
        eFP_Wn_CH1 = 4'($urandom);
        eFP_Wn_CH2 = ($urandom_range(0, 3) == 0) ? eFP_Wn_CH1 : 4'($urandom);
        INT_Neg = 1'($urandom); INT_Zero = 1'($urandom);
        FP_Neg_CH1 = 1'($urandom); FP_Zero_CH1 = 1'($urandom);
        FP_Neg_CH2 = 1'($urandom); FP_Zero_CH2 = 1'($urandom);
        ra = ($urandom_range(0, 2) == 0) ? ewn1 : 4'($urandom);
        rb = ($urandom_range(0, 2) == 0) ? ewn2 : 4'($urandom);
        fr1a = ($urandom_range(0, 2) == 0) ? eFP_Wn_CH1 : 4'($urandom);
        fr1b = 4'($urandom);
        fr2a = ($urandom_range(0, 2) == 0) ? eFP_Wn_CH2 : 4'($urandom);
        fr2b = 4'($urandom);
    endtask

    initial begin
        model_clear();
        idle();
        nReset = 0;

        // Reset held while writes of 0xDEADBEEF are driven everywhere
        ewreg1 = 1; ewreg2 = 1; eFP_WReg_CH1 = 1; eFP_WReg_CH2 = 1;
        ed1 = 32'hDEADBEEF; ed2 = 32'hDEADBEEF;
        eFP_ed1 = 64'hDEADBEEF; eFP_ed2 = 64'hDEADBEEF;
        INT_Neg = 1; INT_Zero = 1; FP_Neg_CH1 = 1; FP_Zero_CH1 = 1; FP_Neg_CH2 = 1; FP_Zero_CH2 = 1;
        for (int i = 0; i < 16; i++) begin
            ewn1 = 4'(i); ewn2 = 4'(15 - i); eFP_Wn_CH1 = 4'(i); eFP_Wn_CH2 = 4'(15 - i);
            ra = 4'(i); fr1a = 4'(i);
            #1;
            check("rst.qa", 64'(qa), 64'h0);
            check("rst.fq1a", fq1a, 64'h0);
            step();
        end
        idle();
        #1;
        nReset = 1;
        #1;
        check_all("post_rst");
        check("post_rst.qa", 64'(qa), 64'h0);
        check("post_rst.flags", 64'({IntFlags, FPFlags_CH1, FPFlags_CH2}), 64'h0);

        // Dual integer write to distinct registers
        ewreg1 = 1; ewreg2 = 1; ewn1 = 3; ewn2 = 5; ed1 = 32'h11; ed2 = 32'h22;
        step();
        idle(); ra = 3; rb = 5; #1;
        check("dual.qa", 64'(qa), 64'h11);
        check("dual.qb", 64'(qb), 64'h22);

        // Same-destination collisions: port/channel 2 wins
        ewreg1 = 1; ewreg2 = 1; ewn1 = 7; ewn2 = 7; ed1 = 32'hAAAA; ed2 = 32'h5555;
        eFP_WReg_CH1 = 1; eFP_WReg_CH2 = 1; eFP_Wn_CH1 = 4; eFP_Wn_CH2 = 4;
        eFP_ed1 = 64'h1; eFP_ed2 = 64'h2;
        step();
        idle(); ra = 7; fr2b = 4; #1;
        check("conflict.r7", 64'(qa), 64'h5555);
        check("conflict.f4", fq2b, 64'h2);

        // Same-cycle read of a register being written
        fr1a = 9; eFP_WReg_CH1 = 1; eFP_Wn_CH1 = 9; eFP_ed1 = 64'h3FF0000000000000;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass.same", fq1a, 64'h3FF0000000000000);
`else
        check("bypass.same", fq1a, 64'h0);
`endif
        step();
        idle(); fr1a = 9; #1;
        check("bypass.next", fq1a, 64'h3FF0000000000000);

        // Flag load then hold
        ewreg1 = 1; ewn1 = 1; ed1 = 32'h8000_0000; INT_Neg = 1; INT_Zero = 0;
        eFP_WReg_CH2 = 1; eFP_Wn_CH2 = 2; eFP_ed2 = 64'h1; FP_Neg_CH2 = 1; FP_Zero_CH2 = 0;
        step();
        check("flag.int_load", 64'(IntFlags), 64'h2);
        check("flag.fp2_load", 64'(FPFlags_CH2), 64'h2);
        idle(); INT_Zero = 1; FP_Zero_CH2 = 1; FP_Neg_CH1 = 1;
        step();
        check("flag.int_hold", 64'(IntFlags), 64'h2);
        check("flag.fp2_hold", 64'(FPFlags_CH2), 64'h2);
        check("flag.fp1_hold", 64'(FPFlags_CH1), 64'h0);

        // Asynchronous reset between edges, held across a pending write
        idle(); ewreg1 = 1; ewn1 = 2; ed1 = 32'h1234;
        step();
        idle(); ra = 2; #1;
        check("arst.before", 64'(qa), 64'h1234);
        #1; nReset = 0; model_clear(); #1;
        check("arst.immediate", 64'(qa), 64'h0);
        ewreg1 = 1; ewn1 = 2; ed1 = 32'h5678;
        step();
        idle(); ra = 2; nReset = 1; #1;
        check("arst.lost", 64'(qa), 64'h0);
        check_all("arst");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            #1;
            check_all("rnd");
            step();
        end
        idle(); #1;
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); fr1a = 4'(i); fr2b = 4'(15 - i); #1;
            check("final.int", 64'(qa), 64'(m_int[i]));
            check("final.fp", fq1a, m_fp[i]);
            check("final.fp2b", fq2b, m_fp[15 - i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
